// File: rtl/dispatch_arbiter_pkg.sv
// Shared issue-stage types: reservation-station payload fields and the held issue slot.
package dispatch_arbiter_pkg;

  localparam int RSV_CAPACITY = 8;

  // FU encoding: INT = 0, FP = 1
  typedef logic [0:0] FuncUnitType_t;
  typedef logic [3:0] FuncCode_t;
  typedef logic [5:0] VRegIdx_t;
  typedef logic [$clog2(RSV_CAPACITY)-1:0] RsvIdx_t;

  typedef struct packed {
    RsvIdx_t   tag;
    FuncCode_t funcCode;
    VRegIdx_t  vrdIdx;
    logic      hasRd;
  } IssueSlot_t;

endpackage

// File: rtl/dispatch_arbiter_rr.sv
// Combinational round-robin picker: first request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grantIdx,
  output logic         anyGrant
);

  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    grantIdx = '0;
    anyGrant = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!anyGrant && req[W'(idx)]) begin
        anyGrant          = 1'b1;
        grant[W'(idx)]    = 1'b1;
        grantIdx          = W'(idx);
      end
    end
  end

endmodule

// File: rtl/dispatch_arbiter.sv
// Issue stage: per-FU round-robin selection of Ready stations into valid/ready output slots.
module dispatch_arbiter
  import dispatch_arbiter_pkg::*;
#(
  parameter int NUM_RS = RSV_CAPACITY,
  parameter int NUM_FU = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_RS-1:0]         rsReady,
  input  FuncUnitType_t             rsFuncUnit    [NUM_RS],
  input  FuncCode_t                 rsFuncCode    [NUM_RS],
  input  VRegIdx_t                  rsVrdIdx      [NUM_RS],
  input  logic [NUM_RS-1:0]         rsHasRd,
  output logic [NUM_RS-1:0]         dispatchAck,
  input  logic                      flush,
  output logic [NUM_FU-1:0]         issueValid,
  input  logic [NUM_FU-1:0]         issueReady,
  output logic [$clog2(NUM_RS)-1:0] issueTag      [NUM_FU],
  output FuncCode_t                 issueFuncCode [NUM_FU],
  output VRegIdx_t                  issueVrdIdx   [NUM_FU],
  output logic [NUM_FU-1:0]         issueHasRd
);

  localparam int TAG_W = $clog2(NUM_RS);

  logic [NUM_RS-1:0] ackVec [NUM_FU];

  genvar gi;
  for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
    logic [NUM_RS-1:0] cand;
    logic [NUM_RS-1:0] grant;
    logic [TAG_W-1:0]  grantIdx;
    logic [TAG_W-1:0]  rrPtr;
    logic              anyGrant;
    logic              canLoad;
    logic              slotValid;
    IssueSlot_t        slot;

    always_comb begin
      cand = '0;
      for (int i = 0; i < NUM_RS; i++) begin
        cand[i] = rsReady[i] && (rsFuncUnit[i] == FuncUnitType_t'(gi));
      end
    end

    rr_arbiter #(.N(NUM_RS)) u_arb (
      .req      (cand),
      .ptr      (rrPtr),
      .grant    (grant),
      .grantIdx (grantIdx),
      .anyGrant (anyGrant)
    );

    // Gating the ack with canLoad also suppresses it under flush and reset.
    assign canLoad    = rstn && !flush && (!slotValid || issueReady[gi]);
    assign ackVec[gi] = (canLoad && anyGrant) ? grant : '0;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        slotValid <= 1'b0;
        slot      <= '0;
        rrPtr     <= '0;
      end else if (flush) begin
        slotValid <= 1'b0;
      end else if (canLoad) begin
        slotValid <= anyGrant;
        if (anyGrant) begin
          slot <= '{tag:      RsvIdx_t'(grantIdx),
                    funcCode: rsFuncCode[grantIdx],
                    vrdIdx:   rsVrdIdx[grantIdx],
                    hasRd:    rsHasRd[grantIdx]};
          rrPtr <= (grantIdx == TAG_W'(NUM_RS - 1)) ? '0 : grantIdx + TAG_W'(1);
        end
      end
    end

    assign issueValid[gi]    = slotValid;
    assign issueTag[gi]      = TAG_W'(slot.tag);
    assign issueFuncCode[gi] = slot.funcCode;
    assign issueVrdIdx[gi]   = slot.vrdIdx;
    assign issueHasRd[gi]    = slot.hasRd;
  end

  always_comb begin
    dispatchAck = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      dispatchAck = dispatchAck | ackVec[f];
    end
  end

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Bench for dispatch_arbiter: directed vector table, a throughput sequence, and a randomized run against a reference model.
module tb_dispatch_arbiter;
  import dispatch_arbiter_pkg::*;

  localparam int N = RSV_CAPACITY;
  localparam int F = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, flush;
  logic [N-1:0]  rsReady, rsHasRd, dispatchAck;
  FuncUnitType_t rsFuncUnit [N];
  FuncCode_t     rsFuncCode [N];
  VRegIdx_t      rsVrdIdx   [N];
  logic [F-1:0]  issueValid, issueReady, issueHasRd;
  logic [2:0]    issueTag      [F];
  FuncCode_t     issueFuncCode [F];
  VRegIdx_t      issueVrdIdx   [F];

  dispatch_arbiter #(.NUM_RS(N), .NUM_FU(F)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .rsReady       (rsReady),
    .rsFuncUnit    (rsFuncUnit),
    .rsFuncCode    (rsFuncCode),
    .rsVrdIdx      (rsVrdIdx),
    .rsHasRd       (rsHasRd),
    .dispatchAck   (dispatchAck),
    .flush         (flush),
    .issueValid    (issueValid),
    .issueReady    (issueReady),
    .issueTag      (issueTag),
    .issueFuncCode (issueFuncCode),
    .issueVrdIdx   (issueVrdIdx),
    .issueHasRd    (issueHasRd)
  );

  int nCmp = 0;
  int nErr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ready, input logic [7:0] fu, input logic [1:0] irdy,
                       input logic fl, input logic rn);
    rsReady = ready;
    for (int i = 0; i < N; i++) rsFuncUnit[i] = FuncUnitType_t'(fu[i]);
    issueReady = irdy;
    flush      = fl;
    rstn       = rn;
  endtask

  // One row = one cycle: inputs, then expected ack (same cycle) and slot state seen in that cycle.
  typedef struct {
    logic [7:0] ready;
    logic [7:0] fu;
    logic [1:0] irdy;
    logic       fl;
    logic       rn;
    logic [7:0] ack;
    logic [1:0] valid;
    logic [2:0] tag0;
    logic [2:0] tag1;
  } vec_t;

  vec_t vecs [22];

  // Reference model state
  int  mPtr   [F];
  bit  mValid [F];
  int  mTag   [F];
  int  mFc    [F];
  int  mVrd   [F];
  bit  mHas   [F];
  int  mGnt   [F];
  logic [N-1:0] mAck;
  logic [N-1:0] sReady;

  function automatic void modelGrant();
    int idx;
    mAck = '0;
    for (int f = 0; f < F; f++) begin
      mGnt[f] = -1;
      if (rstn && !flush && (!mValid[f] || issueReady[f])) begin
        for (int k = 0; k < N; k++) begin
          idx = (mPtr[f] + k) % N;
          if (mGnt[f] < 0 && rsReady[idx] && int'(rsFuncUnit[idx]) == f) mGnt[f] = idx;
        end
      end
      if (mGnt[f] >= 0) mAck[mGnt[f]] = 1'b1;
    end
  endfunction

  function automatic void modelEdge();
    for (int f = 0; f < F; f++) begin
      if (!rstn) begin
        mValid[f] = 0; mPtr[f] = 0; mTag[f] = 0; mFc[f] = 0; mVrd[f] = 0; mHas[f] = 0;
      end else if (flush) begin
        mValid[f] = 0;
      end else if (!mValid[f] || issueReady[f]) begin
        if (mGnt[f] >= 0) begin
          mValid[f] = 1;
          mTag[f]   = mGnt[f];
          mFc[f]    = int'(rsFuncCode[mGnt[f]]);
          mVrd[f]   = int'(rsVrdIdx[mGnt[f]]);
          mHas[f]   = rsHasRd[mGnt[f]];
          mPtr[f]   = (mGnt[f] + 1) % N;
        end else begin
          mValid[f] = 0;
        end
      end
    end
  endfunction

  initial begin
    logic [7:0] held;

    vecs[0]  = '{8'hFF, 8'h00, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 3'd0, 3'd0};
    vecs[1]  = '{8'h24, 8'h00, 2'b11, 1'b0, 1'b1, 8'h04, 2'b00, 3'd0, 3'd0};
    vecs[2]  = '{8'h20, 8'h00, 2'b11, 1'b0, 1'b1, 8'h20, 2'b01, 3'd2, 3'd0};
    vecs[3]  = '{8'h00, 8'h00, 2'b11, 1'b0, 1'b1, 8'h00, 2'b01, 3'd5, 3'd0};
    vecs[4]  = '{8'h18, 8'h10, 2'b11, 1'b0, 1'b1, 8'h18, 2'b00, 3'd5, 3'd0};
    vecs[5]  = '{8'h00, 8'h10, 2'b11, 1'b0, 1'b1, 8'h00, 2'b11, 3'd3, 3'd4};
    vecs[6]  = '{8'h02, 8'h00, 2'b11, 1'b0, 1'b1, 8'h02, 2'b00, 3'd3, 3'd4};
    vecs[7]  = '{8'h40, 8'h00, 2'b10, 1'b0, 1'b1, 8'h00, 2'b01, 3'd1, 3'd4};
    vecs[8]  = '{8'h40, 8'h00, 2'b10, 1'b0, 1'b1, 8'h00, 2'b01, 3'd1, 3'd4};
    vecs[9]  = '{8'h40, 8'h00, 2'b10, 1'b0, 1'b1, 8'h00, 2'b01, 3'd1, 3'd4};
    vecs[10] = '{8'h40, 8'h00, 2'b11, 1'b0, 1'b1, 8'h40, 2'b01, 3'd1, 3'd4};
    vecs[11] = '{8'h00, 8'h00, 2'b11, 1'b0, 1'b1, 8'h00, 2'b01, 3'd6, 3'd4};
    vecs[12] = '{8'h81, 8'h00, 2'b11, 1'b0, 1'b1, 8'h80, 2'b00, 3'd6, 3'd4};
    vecs[13] = '{8'h01, 8'h00, 2'b11, 1'b0, 1'b1, 8'h01, 2'b01, 3'd7, 3'd4};
    vecs[14] = '{8'h03, 8'h00, 2'b11, 1'b0, 1'b1, 8'h02, 2'b01, 3'd0, 3'd4};
    vecs[15] = '{8'h11, 8'h10, 2'b11, 1'b0, 1'b1, 8'h11, 2'b01, 3'd1, 3'd4};
    vecs[16] = '{8'h02, 8'h00, 2'b00, 1'b1, 1'b1, 8'h00, 2'b11, 3'd0, 3'd4};
    vecs[17] = '{8'h02, 8'h00, 2'b11, 1'b0, 1'b1, 8'h02, 2'b00, 3'd0, 3'd4};
    vecs[18] = '{8'h48, 8'h40, 2'b11, 1'b0, 1'b1, 8'h48, 2'b01, 3'd1, 3'd4};
    vecs[19] = '{8'hFF, 8'hF0, 2'b11, 1'b0, 1'b0, 8'h00, 2'b11, 3'd3, 3'd6};
    vecs[20] = '{8'hFF, 8'hF0, 2'b11, 1'b0, 1'b1, 8'h11, 2'b00, 3'd0, 3'd0};
    vecs[21] = '{8'h00, 8'hF0, 2'b11, 1'b0, 1'b1, 8'h00, 2'b11, 3'd0, 3'd4};

    for (int i = 0; i < N; i++) begin
      rsFuncCode[i] = FuncCode_t'(i);
      rsVrdIdx[i]   = VRegIdx_t'(i + 8);
    end
    rsHasRd = 8'hAA;
    drive(8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);

    @(negedge clk);
    #1;
    chk("reset funcCode0", 32'(issueFuncCode[0]), 32'd0);
    chk("reset vrdIdx1", 32'(issueVrdIdx[1]), 32'd0);
    chk("reset hasRd", 32'(issueHasRd), 32'd0);

    // Directed table
    for (int r = 0; r < 22; r++) begin
      @(negedge clk);
      drive(vecs[r].ready, vecs[r].fu, vecs[r].irdy, vecs[r].fl, vecs[r].rn);
      #1;
      chk($sformatf("row%0d ack", r), 32'(dispatchAck), 32'(vecs[r].ack));
      chk($sformatf("row%0d valid", r), 32'(issueValid), 32'(vecs[r].valid));
      chk($sformatf("row%0d tag0", r), 32'(issueTag[0]), 32'(vecs[r].tag0));
      chk($sformatf("row%0d tag1", r), 32'(issueTag[1]), 32'(vecs[r].tag1));
      $display("row %0d: ack=%h valid=%b tag0=%0d tag1=%0d", r, dispatchAck, issueValid,
               issueTag[0], issueTag[1]);
    end

    // Throughput on FP: four held stations drain one per cycle, payload follows the tag
    @(negedge clk);
    drive(8'h00, 8'hF0, 2'b11, 1'b0, 1'b0);
    held = 8'hF0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(held, 8'hF0, 2'b11, 1'b0, 1'b1);
      #1;
      chk($sformatf("thru%0d ack", k), 32'(dispatchAck), (k < 4) ? (32'd1 << (4 + k)) : 32'd0);
      chk($sformatf("thru%0d valid1", k), 32'(issueValid[1]), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk($sformatf("thru%0d tag1", k), 32'(issueTag[1]), 32'(3 + k));
        chk($sformatf("thru%0d funcCode1", k), 32'(issueFuncCode[1]), 32'(3 + k));
        chk($sformatf("thru%0d vrdIdx1", k), 32'(issueVrdIdx[1]), 32'(11 + k));
      end
      $display("thru %0d: ack=%h valid=%b tag1=%0d", k, dispatchAck, issueValid, issueTag[1]);
      held = held & ~dispatchAck;
    end

    // Randomized run against the model
    @(negedge clk);
    drive(8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    for (int f = 0; f < F; f++) begin
      mValid[f] = 0; mPtr[f] = 0; mTag[f] = 0; mFc[f] = 0; mVrd[f] = 0; mHas[f] = 0;
    end
    sReady = '0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!sReady[i] && $urandom_range(2) == 0) begin
          sReady[i]     = 1'b1;
          rsFuncUnit[i] = FuncUnitType_t'($urandom_range(1));
          rsFuncCode[i] = FuncCode_t'($urandom);
          rsVrdIdx[i]   = VRegIdx_t'($urandom);
          rsHasRd[i]    = 1'($urandom);
        end
      end
      rsReady = sReady;
      for (int f = 0; f < F; f++) issueReady[f] = ($urandom_range(3) != 0);
      flush = ($urandom_range(15) == 0);
      rstn  = ($urandom_range(63) != 0);
      #1;
      modelGrant();
      chk($sformatf("rnd%0d ack", c), 32'(dispatchAck), 32'(mAck));
      for (int f = 0; f < F; f++) begin
        chk($sformatf("rnd%0d valid%0d", c, f), 32'(issueValid[f]), 32'(mValid[f]));
        if (mValid[f]) begin
          chk($sformatf("rnd%0d tag%0d", c, f), 32'(issueTag[f]), 32'(mTag[f]));
          chk($sformatf("rnd%0d funcCode%0d", c, f), 32'(issueFuncCode[f]), 32'(mFc[f]));
          chk($sformatf("rnd%0d vrdIdx%0d", c, f), 32'(issueVrdIdx[f]), 32'(mVrd[f]));
          chk($sformatf("rnd%0d hasRd%0d", c, f), 32'(issueHasRd[f]), 32'(mHas[f]));
        end
      end
      $display("rnd %0d: rstn=%b flush=%b ready=%h irdy=%b ack=%h valid=%b", c, rstn, flush,
               rsReady, issueReady, dispatchAck, issueValid);
      modelEdge();
      sReady = sReady & ~mAck;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
